// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and constants for the FIFO pop-side word packer.
package fifo_pkg;
  typedef enum logic {COLLECT = 1'b0, SEND = 1'b1} state_t;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_PACK_WORDS = 4;
  localparam int unsigned MARKER_BIT = DEF_DATA_WIDTH;
  function automatic int unsigned lane_cnt_w(input int unsigned pack_words);
    return $clog2(pack_words);
  endfunction
endpackage

// File: rtl/fifo_word_packer_if.sv
// fifo_word_packer_if: FIFO pop port plus packed-beat output bus of the packer.
interface fifo_word_packer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PACK_WORDS = 4
);
  logic [DATA_WIDTH:0]              in_data_i;
  logic                             in_valid_i;
  logic                             in_grant_o;
  logic [PACK_WORDS*DATA_WIDTH-1:0] out_data_o;
  logic [PACK_WORDS-1:0]            out_keep_o;
  logic                             out_last_o;
  logic                             out_valid_o;
  logic                             out_grant_i;
  modport master (
    input  in_data_i, in_valid_i, out_grant_i,
    output in_grant_o, out_data_o, out_keep_o, out_last_o, out_valid_o
  );
  modport slave (
    output in_data_i, in_valid_i, out_grant_i,
    input  in_grant_o, out_data_o, out_keep_o, out_last_o, out_valid_o
  );
endinterface

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: packs up to PACK_WORDS FIFO payloads into one wide beat,
// closing early on the last-word marker.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PACK_WORDS = DEF_PACK_WORDS
) (
  input logic clk,
  input logic rst_n,
  fifo_word_packer_if.master bus
);
  localparam int unsigned LANE_CNT_W = lane_cnt_w(PACK_WORDS);
  localparam int unsigned MARK = DATA_WIDTH;
  state_t                  state_q, state_d;
  logic [LANE_CNT_W-1:0]   cnt_q, cnt_d, base_cnt;
  logic [PACK_WORDS-1:0]   keep_q, keep_d;
  logic                    last_q, last_d;
  logic                    take, rel, mark, close;
  logic [DATA_WIDTH-1:0]   payload;
  // A release frees the lanes in the same cycle, so a new word starts at lane 0.
  assign rel      = (state_q == SEND) && bus.out_grant_i;
  assign take     = bus.in_valid_i && bus.in_grant_o;
  assign mark     = bus.in_data_i[MARK];
  assign payload  = bus.in_data_i[DATA_WIDTH-1:0];
  assign base_cnt = rel ? '0 : cnt_q;
  assign close    = (base_cnt == LANE_CNT_W'(PACK_WORDS - 1)) || mark;
  assign bus.in_grant_o  = (state_q == COLLECT) || bus.out_grant_i;
  assign bus.out_valid_o = (state_q == SEND);
  assign bus.out_keep_o  = keep_q;
  assign bus.out_last_o  = last_q;
  always_comb begin
    state_d = take ? (close ? SEND : COLLECT) : (rel ? COLLECT : state_q);
    cnt_d   = take ? (close ? '0 : base_cnt + LANE_CNT_W'(1)) : (rel ? '0 : cnt_q);
    last_d  = take ? mark : (!rel && last_q);
    for (int k = 0; k < PACK_WORDS; k++)
      keep_d[k] = (take && base_cnt == LANE_CNT_W'(k)) || (!rel && keep_q[k]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end
  for (genvar g = 0; g < PACK_WORDS; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_q, lane_d;
    always_comb lane_d = (take && base_cnt == LANE_CNT_W'(g)) ? payload : (rel ? '0 : lane_q);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lane_q <= '0;
      else        lane_q <= lane_d;
    end
    assign bus.out_data_o[g*DATA_WIDTH +: DATA_WIDTH] = lane_q;
  end
endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: directed and random stimulus checked against a queue-based beat model.
module tb_fifo_word_packer;
  typedef struct {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int acc = 0;
  int beats = 0;
  beat_t expq[$];
  logic [31:0] cur[$];
  fifo_word_packer_if #(.DATA_WIDTH(32), .PACK_WORDS(4)) bus ();
  fifo_word_packer #(.DATA_WIDTH(32), .PACK_WORDS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_word(input logic [32:0] w);
    beat_t b;
    cur.push_back(w[31:0]);
    acc++;
    if (cur.size() == 4 || w[32]) begin
      b.data = '0;
      foreach (cur[i]) b.data[i*32 +: 32] = cur[i];
      b.keep = 4'((1 << cur.size()) - 1);
      b.last = w[32];
      expq.push_back(b);
      cur.delete();
    end
  endtask
  task automatic cyc(input logic v, input logic [32:0] d, input logic g);
    logic ev, take, rel;
    bus.in_valid_i = v;
    bus.in_data_i = d;
    bus.out_grant_i = g;
    #1;
    ev = (expq.size() != 0);
    chk("out_valid", 128'(bus.out_valid_o), 128'(ev));
    chk("in_grant", 128'(bus.in_grant_o), 128'(!ev || g));
    if (ev) begin
      chk("out_data", bus.out_data_o, expq[0].data);
      chk("out_keep", 128'(bus.out_keep_o), 128'(expq[0].keep));
      chk("out_last", 128'(bus.out_last_o), 128'(expq[0].last));
    end
    take = v && bus.in_grant_o;
    rel = bus.out_valid_o && g;
    if (rel && ev) begin
      void'(expq.pop_front());
      beats++;
    end
    if (take) model_word(d);
    @(negedge clk);
  endtask
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1);
  endtask
  initial begin
    bus.in_valid_i = 1'b0;
    bus.in_data_i = '0;
    bus.out_grant_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(bus.out_valid_o), 128'(0));
    chk("rst_keep", 128'(bus.out_keep_o), 128'(0));
    chk("rst_last", 128'(bus.out_last_o), 128'(0));
    chk("rst_data", bus.out_data_o, 128'(0));
    chk("rst_grant", 128'(bus.in_grant_o), 128'(1));
    rst_n = 1'b1;
    @(negedge clk);
    // full beats, continuous grant
    for (int i = 1; i <= 8; i++) cyc(1'b1, {1'b0, 32'(i)}, 1'b1);
    drain(2);
    chk("full_acc", 128'(acc), 128'(8));
    chk("full_beats", 128'(beats), 128'(2));
    // early close then a new beat
    cyc(1'b1, {1'b0, 32'hA}, 1'b1);
    cyc(1'b1, {1'b1, 32'hB}, 1'b1);
    cyc(1'b1, {1'b1, 32'hC}, 1'b1);
    drain(2);
    // single-word packet
    cyc(1'b1, {1'b1, 32'h55}, 1'b1);
    chk("single_lat", 128'(bus.out_valid_o), 128'(1));
    drain(2);
    // backpressure: full beat held for 5 cycles
    for (int i = 0; i < 4; i++) cyc(1'b1, {1'b0, 32'h11 + 32'(i)}, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, {1'b0, 32'h21}, 1'b0);
    acc = 0;
    cyc(1'b1, {1'b1, 32'h21}, 1'b1);
    chk("bp_take", 128'(acc), 128'(1));
    drain(2);
    // reset mid-beat
    cyc(1'b1, {1'b0, 32'h31}, 1'b1);
    cyc(1'b1, {1'b0, 32'h32}, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 128'(bus.out_valid_o), 128'(0));
    chk("midrst_keep", 128'(bus.out_keep_o), 128'(0));
    expq.delete();
    cur.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, {1'b0, 32'h41 + 32'(i)}, 1'b1);
    chk("postrst_keep", 128'(bus.out_keep_o), 128'(4'b1111));
    drain(2);
    // empty source
    beats = 0;
    for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b1);
    chk("empty_beats", 128'(beats), 128'(0));
    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), {1'($urandom_range(0, 3) == 0), 32'($urandom)},
          1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 3; i++) cyc(1'b1, {1'b1, 32'($urandom)}, 1'b1);
    drain(3);
    chk("final_expq", 128'(expq.size()), 128'(0));
    chk("final_cur", 128'(cur.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
